// File: rtl/credit_sender_mpi.sv
// Transmit side of a valid/yummy credit link: local flits are buffered in a
// small FIFO and launched toward dest_i only while far-end credits remain.
module credit_sender_mpi #(
  parameter int DEPTH       = 4,
  parameter int CREDITS     = 1,
  parameter int SENDER_RANK = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] rank_i,
  input  logic [31:0] dest_i,
  input  logic        valid_i,
  input  logic [63:0] data_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [63:0] data_o,
  output logic [31:0] dest_o,
  input  logic        yummy_i,
  output logic [3:0]  credit_o,
  output logic [31:0] sent_cnt_o,
  output logic        err_o
);

  localparam int          PW         = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);
  localparam logic [3:0]  CREDIT_MAX = 4'(CREDITS);
  localparam logic [31:0] RANK       = 32'(SENDER_RANK);

  logic          active;
  logic          push;
  logic          send;

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic [PW:0]   count_next;

  logic [3:0]    credit_reg;
  logic [3:0]    credit_next;
  logic          err_reg;
  logic          err_next;

  logic          valid_reg;
  logic [63:0]   data_reg;
  logic [31:0]   dest_reg;
  logic [31:0]   sent_reg;

  assign active  = (rank_i == RANK);
  // Registered count only: a pop in the same cycle never frees a full FIFO.
  assign ready_o = active && (count_reg != FULL_COUNT);
  assign push    = valid_i && ready_o;
  assign send    = active && (count_reg != '0) && (credit_reg != '0);

  always_comb begin
    count_next = count_reg;
    case ({push, send})
      2'b10:   count_next = count_reg + (PW + 1)'(1);
      2'b01:   count_next = count_reg - (PW + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // A yummy arriving with full credits and no launch is a protocol error;
  // credit saturates rather than wrapping past CREDITS.
  always_comb begin
    credit_next = credit_reg;
    err_next    = err_reg;
    if (active) begin
      if (yummy_i && !send && (credit_reg == CREDIT_MAX)) begin
        err_next = 1'b1;
      end else begin
        credit_next = credit_reg - {3'b000, send} + {3'b000, yummy_i};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      credit_reg <= CREDIT_MAX;
      err_reg    <= 1'b0;
      valid_reg  <= 1'b0;
      data_reg   <= '0;
      dest_reg   <= '0;
      sent_reg   <= '0;
    end else if (active) begin
      count_reg  <= count_next;
      credit_reg <= credit_next;
      err_reg    <= err_next;
      valid_reg  <= send;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (send) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
        data_reg   <= mem[rd_ptr_reg];
        dest_reg   <= dest_i;
        sent_reg   <= sent_reg + 32'd1;
      end
    end
  end

  assign valid_o    = active && valid_reg;
  assign data_o     = active ? data_reg : '0;
  assign dest_o     = dest_reg;
  assign credit_o   = credit_reg;
  assign sent_cnt_o = sent_reg;
  assign err_o      = err_reg;

endmodule

// File: tb/tb_credit_sender_mpi.sv
// Randomized scoreboard bench for credit_sender_mpi with a queue-based
// reference model and an emulated far end returning yummies.
module tb_credit_sender_mpi;

  localparam int DEPTH       = 4;
  localparam int CREDITS     = 2;
  localparam int SENDER_RANK = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rank;
  logic [31:0] dest;
  logic        valid_in;
  logic [63:0] data_in;
  logic        ready;
  logic        valid_out;
  logic [63:0] data_out;
  logic [31:0] dest_out;
  logic        yummy;
  logic [3:0]  credit;
  logic [31:0] sent_cnt;
  logic        err;

  always #5 clk = ~clk;

  credit_sender_mpi #(
    .DEPTH(DEPTH), .CREDITS(CREDITS), .SENDER_RANK(SENDER_RANK)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rank_i(rank), .dest_i(dest),
    .valid_i(valid_in), .data_i(data_in), .ready_o(ready),
    .valid_o(valid_out), .data_o(data_out), .dest_o(dest_out),
    .yummy_i(yummy), .credit_o(credit), .sent_cnt_o(sent_cnt), .err_o(err)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [31:0] r;
  } flit_t;

  int total = 0;
  int bad   = 0;

  // Reference model state: values visible on the DUT outputs this cycle.
  logic [63:0] m_q[$];
  flit_t       exp_q[$];
  int          m_credit;
  int          m_sent;
  bit          m_err;
  bit          m_valid;
  logic [63:0] m_data;
  logic [31:0] m_dest;
  bit          m_accepted;
  int          far_held;
  int          yummy_mode;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Applies one rising edge worth of link rules to the model.
  task automatic model_step();
    bit act;
    bit snd;
    bit psh;
    m_accepted = 1'b0;
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_credit = CREDITS;
      m_sent   = 0;
      m_err    = 1'b0;
      m_valid  = 1'b0;
      m_data   = '0;
      m_dest   = '0;
      far_held = 0;
      return;
    end
    act = (rank == SENDER_RANK);
    if (!act) return;
    snd = (m_q.size() > 0) && (m_credit > 0);
    psh = valid_in && (m_q.size() < DEPTH);
    if (yummy && far_held > 0) far_held--;
    if (snd) begin
      m_data = m_q.pop_front();
      m_dest = dest;
      exp_q.push_back(flit_t'{d: m_data, r: dest});
      m_sent++;
      far_held++;
    end
    m_valid  = snd;
    m_credit = m_credit - int'(snd) + int'(yummy);
    if (m_credit > CREDITS) begin
      m_credit = CREDITS;
      m_err    = 1'b1;
    end
    if (psh) begin
      m_q.push_back(data_in);
      m_accepted = 1'b1;
    end
  endtask

  task automatic tick();
    case (yummy_mode)
      0:       yummy = 1'b0;
      1:       yummy = (far_held > 0);
      2:       yummy = (far_held > 0) && ($urandom_range(0, 2) == 0);
      3:       yummy = 1'b1;
      default: yummy = 1'($urandom_range(0, 1));
    endcase
    dest = $urandom;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_flit(input logic [63:0] d);
    int n;
    valid_in = 1'b1;
    data_in  = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_accepted && n < 200);
    if (!m_accepted) check("push_timeout", 64'(ready), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    yummy_mode = 1;
    valid_in   = 1'b0;
    n = 0;
    while ((m_q.size() > 0 || far_held > 0 || exp_q.size() > 0) && n < 200) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(m_q.size() + far_held + exp_q.size()), 64'd0);
  endtask

  // Monitor: compares every visible output and pops the scoreboard per launch.
  always @(negedge clk) begin
    if (mon_en) begin
      bit act;
      flit_t f;
      act = (rank == SENDER_RANK);
      check("ready_o", 64'(ready), 64'(act && (m_q.size() != DEPTH)));
      check("valid_o", 64'(valid_out), 64'(act && m_valid));
      check("data_o", data_out, act ? m_data : 64'd0);
      check("dest_o", 64'(dest_out), 64'(m_dest));
      check("credit_o", 64'(credit), 64'(m_credit));
      check("credit_range", 64'(credit <= 4'(CREDITS)), 64'd1);
      check("sent_cnt_o", 64'(sent_cnt), 64'(m_sent));
      check("err_o", 64'(err), 64'(m_err));
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 64'(valid_out), 64'd0);
        end else begin
          f = exp_q.pop_front();
          check("sb_data", data_out, f.d);
          check("sb_dest", 64'(dest_out), 64'(f.r));
          $display("launch #%0d data=%h dest=%0d credit=%0d", sent_cnt, data_out, dest_out, credit);
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    rank       = 32'(SENDER_RANK);
    dest       = '0;
    valid_in   = 1'b0;
    data_in    = '0;
    yummy      = 1'b0;
    yummy_mode = 0;
    far_held   = 0;
    #1;
    idle(3);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single flit latency, then credits returned.
    push_flit(64'hAAAA_0001);
    idle(3);
    yummy_mode = 1;
    idle(4);

    // Credit stall: FIFO fills, nothing launches until a yummy.
    yummy_mode = 0;
    for (int i = 0; i < 6; i++) push_flit(64'h5000 + 64'(i));
    idle(5);
    yummy_mode = 1;
    idle(1);
    yummy_mode = 0;
    idle(4);
    drain();

    // Launch and yummy in the same cycle keep credit steady.
    yummy_mode = 1;
    for (int i = 0; i < 8; i++) push_flit(64'h100 + 64'(i));
    drain();

    // FIFO wrap with intermittent yummies.
    yummy_mode = 2;
    for (int i = 0; i < 10; i++) push_flit(64'(i));
    drain();

    // Randomized traffic.
    yummy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      valid_in = 1'($urandom_range(0, 1));
      data_in  = {$urandom, $urandom};
      tick();
    end
    drain();

    // Overflow: yummy at full credit sets a sticky error.
    do_reset();
    yummy_mode = 3;
    idle(1);
    yummy_mode = 0;
    idle(3);
    check("err_sticky", 64'(err), 64'd1);

    // Inactive rank ignores everything.
    do_reset();
    rank       = 32'(SENDER_RANK + 1 + int'($urandom_range(0, 50)));
    yummy_mode = 4;
    for (int i = 0; i < 20; i++) begin
      valid_in = 1'($urandom_range(0, 1));
      data_in  = {$urandom, $urandom};
      tick();
    end
    valid_in   = 1'b0;
    yummy_mode = 0;
    idle(1);
    rank = 32'(SENDER_RANK);
    do_reset();

    // Mid-operation reset with three flits queued.
    yummy_mode = 0;
    for (int i = 0; i < 5; i++) push_flit(64'hDEAD_0000 + 64'(i));
    idle(2);
    check("queued_before_reset", 64'(credit), 64'd0);
    do_reset();
    yummy_mode = 1;
    idle(10);

    @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
